// File: rtl/rx_seq_strip.sv
// rx_seq_strip: RX-side sequence-word stripper and continuity checker.
// Takes the Aurora RX AXI-Stream, which has no backpressure. In strip mode the trailing
// 32-bit sequence word of each frame is removed and checked for continuity. Frames are
// buffered in a first-word fall-through FIFO towards the user master port.
// Optional feature macro: RX_SEQ_STATS_EN enables the saturating statistics counters
// (frame_cnt, seq_err_cnt, drop_cnt, runt_cnt). When the macro is undefined, those
// outputs are tied to zero.
module rx_seq_strip #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  m_axis_aclk,
  input  logic                  sys_reset,
  // RX stream, no tready: every valid beat must be consumed
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  // User stream
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  // Control and status
  input  logic                  ctrl_strip_seq_en,
  input  logic                  clr_stats,
  output logic [31:0]           seq_last,
  output logic                  seq_err,
  output logic                  ovf_err,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic [CNT_WIDTH-1:0]  seq_err_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic [CNT_WIDTH-1:0]  runt_cnt
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic {HoldEmpty, HoldFull} hold_state_e;
  typedef enum logic {SeqSync, SeqTrack} seq_state_e;

  // Frame tracking / hold register
  logic                  strip_q, strip_d;
  logic                  strip_eff;
  logic                  in_frame_q, in_frame_d;
  logic                  boundary;
  hold_state_e           hold_state_q, hold_state_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;

  // Push request towards the FIFO
  logic                  push_req;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  push_last;

  // Sequence checking
  logic                  seq_chk;
  seq_state_e            seq_state_q, seq_state_d;
  seq_state_e            seq_state_cur;
  logic [31:0]           seq_last_q, seq_last_d;
  logic                  seq_err_q, seq_err_d;

  // FIFO
  logic [DATA_WIDTH:0]   fifo_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  fifo_valid;
  logic                  fifo_full;
  logic                  pop;
  logic                  push_ok;
  logic                  drop;
  logic                  ovf_err_q, ovf_err_d;

  // A frame boundary means no partial frame is pending anywhere in the input stage.
  assign boundary  = (hold_state_q == HoldEmpty) && !in_frame_q;
  // The mode is sampled at the boundary so that the first beat of a frame already uses it.
  assign strip_eff = boundary ? ctrl_strip_seq_en : strip_q;

  // Hold-register FSM: delays payload by one word so the trailing word can be dropped
  always_comb begin
    strip_d      = strip_eff;
    in_frame_d   = in_frame_q;
    hold_state_d = hold_state_q;
    hold_data_d  = hold_data_q;
    push_req     = 1'b0;
    push_data    = '0;
    push_last    = 1'b0;
    seq_chk      = 1'b0;
    if (s_axis_tvalid) begin
      in_frame_d = !s_axis_tlast;
      if (strip_eff) begin
        unique case (hold_state_q)
          HoldEmpty: begin
            if (!s_axis_tlast) begin
              hold_data_d  = s_axis_tdata;
              hold_state_d = HoldFull;
            end else begin
              // Runt frame: the only beat is the sequence word
              seq_chk = 1'b1;
            end
          end
          HoldFull: begin
            push_req  = 1'b1;
            push_data = hold_data_q;
            push_last = s_axis_tlast;
            if (s_axis_tlast) begin
              seq_chk      = 1'b1;
              hold_state_d = HoldEmpty;
            end else begin
              hold_data_d = s_axis_tdata;
            end
          end
          default: ;
        endcase
      end else begin
        push_req  = 1'b1;
        push_data = s_axis_tdata;
        push_last = s_axis_tlast;
      end
    end
  end

  // Sequence FSM: a fresh enable of strip mode resynchronises the tracker
  always_comb begin
    seq_state_cur = (strip_eff && !strip_q) ? SeqSync : seq_state_q;
    seq_state_d   = seq_state_cur;
    seq_last_d    = seq_last_q;
    seq_err_d     = 1'b0;
    if (seq_chk) begin
      seq_last_d  = s_axis_tdata;
      seq_state_d = SeqTrack;
      if ((seq_state_cur == SeqTrack) && (s_axis_tdata != seq_last_q + 32'd1)) begin
        seq_err_d = 1'b1;
      end
    end
  end

  // FIFO control: a full FIFO still accepts a push when a pop frees a slot this cycle
  always_comb begin
    fifo_valid = (count_q != '0);
    fifo_full  = (count_q == CntW'(FIFO_DEPTH));
    pop        = fifo_valid && m_axis_tready;
    push_ok    = push_req && (!fifo_full || pop);
    drop       = push_req && !push_ok;
    wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    if (clr_stats) begin
      ovf_err_d = 1'b0;
    end else if (drop) begin
      ovf_err_d = 1'b1;
    end else begin
      ovf_err_d = ovf_err_q;
    end
  end

  // Control and status state
  always_ff @(posedge m_axis_aclk or posedge sys_reset) begin
    if (sys_reset) begin
      strip_q      <= 1'b0;
      in_frame_q   <= 1'b0;
      hold_state_q <= HoldEmpty;
      hold_data_q  <= '0;
      seq_state_q  <= SeqSync;
      seq_last_q   <= '0;
      seq_err_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ovf_err_q    <= 1'b0;
    end else begin
      strip_q      <= strip_d;
      in_frame_q   <= in_frame_d;
      hold_state_q <= hold_state_d;
      hold_data_q  <= hold_data_d;
      seq_state_q  <= seq_state_d;
      seq_last_q   <= seq_last_d;
      seq_err_q    <= seq_err_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ovf_err_q    <= ovf_err_d;
    end
  end

  // FIFO storage, no reset needed: contents are qualified by count_q
  always_ff @(posedge m_axis_aclk) begin
    if (push_ok) begin
      fifo_mem_q[wr_ptr_q] <= {push_last, push_data};
    end
  end

  assign m_axis_tvalid = fifo_valid;
  assign m_axis_tdata  = fifo_valid ? fifo_mem_q[rd_ptr_q][DATA_WIDTH-1:0] : '0;
  assign m_axis_tlast  = fifo_valid ? fifo_mem_q[rd_ptr_q][DATA_WIDTH] : 1'b0;
  assign seq_last      = seq_last_q;
  assign seq_err       = seq_err_q;
  assign ovf_err       = ovf_err_q;

`ifdef RX_SEQ_STATS_EN
  logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_WIDTH-1:0] seq_err_cnt_q, seq_err_cnt_d;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_WIDTH-1:0] runt_cnt_q, runt_cnt_d;
  logic                 frame_inc;
  logic                 runt_inc;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign frame_inc = s_axis_tvalid && s_axis_tlast;
  assign runt_inc  = frame_inc && strip_eff && (hold_state_q == HoldEmpty);

  // Saturating counters; a clear pulse overrides a coincident increment
  always_comb begin
    frame_cnt_d   = frame_inc ? sat_inc(frame_cnt_q) : frame_cnt_q;
    seq_err_cnt_d = seq_err_d ? sat_inc(seq_err_cnt_q) : seq_err_cnt_q;
    drop_cnt_d    = drop ? sat_inc(drop_cnt_q) : drop_cnt_q;
    runt_cnt_d    = runt_inc ? sat_inc(runt_cnt_q) : runt_cnt_q;
    if (clr_stats) begin
      frame_cnt_d   = '0;
      seq_err_cnt_d = '0;
      drop_cnt_d    = '0;
      runt_cnt_d    = '0;
    end
  end

  // Counter registers
  always_ff @(posedge m_axis_aclk or posedge sys_reset) begin
    if (sys_reset) begin
      frame_cnt_q   <= '0;
      seq_err_cnt_q <= '0;
      drop_cnt_q    <= '0;
      runt_cnt_q    <= '0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      seq_err_cnt_q <= seq_err_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
      runt_cnt_q    <= runt_cnt_d;
    end
  end

  assign frame_cnt   = frame_cnt_q;
  assign seq_err_cnt = seq_err_cnt_q;
  assign drop_cnt    = drop_cnt_q;
  assign runt_cnt    = runt_cnt_q;
`else
  assign frame_cnt   = '0;
  assign seq_err_cnt = '0;
  assign drop_cnt    = '0;
  assign runt_cnt    = '0;
`endif

endmodule

// File: tb/tb_rx_seq_strip.sv
// Bench for rx_seq_strip: directed scenarios plus randomized frames, checked against a
// frame-level reference model (expected output queue, sequence tracker, counters).
module tb_rx_seq_strip;

  logic        clk = 1'b0;
  logic        sys_reset;
  logic        s_valid, s_last;
  logic [31:0] s_data;
  logic        m_valid, m_last, m_ready;
  logic [31:0] m_data;
  logic        ctrl, clr;
  logic [31:0] seq_last;
  logic        seq_err, ovf_err;
  logic [15:0] frame_cnt, seq_err_cnt, drop_cnt, runt_cnt;

  logic dir_rdy, rnd_rdy, rnd_mode;
  assign m_ready = rnd_mode ? rnd_rdy : dir_rdy;

  always #5 clk = ~clk;

  rx_seq_strip dut (
    .m_axis_aclk      (clk),
    .sys_reset        (sys_reset),
    .s_axis_tvalid    (s_valid),
    .s_axis_tdata     (s_data),
    .s_axis_tlast     (s_last),
    .m_axis_tvalid    (m_valid),
    .m_axis_tdata     (m_data),
    .m_axis_tlast     (m_last),
    .m_axis_tready    (m_ready),
    .ctrl_strip_seq_en(ctrl),
    .clr_stats        (clr),
    .seq_last         (seq_last),
    .seq_err          (seq_err),
    .ovf_err          (ovf_err),
    .frame_cnt        (frame_cnt),
    .seq_err_cnt      (seq_err_cnt),
    .drop_cnt         (drop_cnt),
    .runt_cnt         (runt_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference model state
  logic [32:0] exp_q[$];
  logic [31:0] pl[$];
  bit          m_prev_strip;
  bit          m_sync;
  logic [31:0] m_seq_last;
  int          m_frames, m_serr, m_drops, m_runts;
  bit          m_ovf;
  bit          last_exp_err;

  function automatic logic [63:0] exp_cnt(input int v);
`ifdef RX_SEQ_STATS_EN
    return 64'(v);
`else
    return 64'(v - v);
`endif
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_prev_strip = 0;
    m_sync       = 1;
    m_seq_last   = '0;
    m_frames     = 0;
    m_serr       = 0;
    m_drops      = 0;
    m_runts      = 0;
    m_ovf        = 0;
  endtask

  task automatic model_clr();
    m_frames = 0;
    m_serr   = 0;
    m_drops  = 0;
    m_runts  = 0;
    m_ovf    = 0;
  endtask

  // Continuity rule on a stripped sequence word
  task automatic model_seq(input logic [31:0] s);
    last_exp_err = 0;
    if (!m_sync && (s != m_seq_last + 32'd1)) begin
      last_exp_err = 1;
      m_serr++;
    end
    m_sync     = 0;
    m_seq_last = s;
  endtask

  // Inputs change 1 time unit after the rising edge
  task automatic beat(input logic [31:0] d, input logic l);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic maybe_gap(input bit gaps);
    if (gaps && ($urandom_range(0, 1) == 1)) idle($urandom_range(1, 2));
  endtask

  // Sends pl as payload; the frame mode is the control value at the first beat
  task automatic send_frame(input logic [31:0] seq, input bit toggle_mid, input bit gaps);
    bit   mode;
    int   n;
    logic l;
    mode = ctrl;
    n    = pl.size();
    if (mode && !m_prev_strip) m_sync = 1;
    m_prev_strip = mode;
    m_frames++;
    last_exp_err = 0;
    for (int i = 0; i < n; i++) begin
      l = (i == n - 1);
      exp_q.push_back({l, pl[i]});
    end
    if (mode) begin
      if (n == 0) m_runts++;
      model_seq(seq);
      for (int i = 0; i < n; i++) begin
        maybe_gap(gaps);
        beat(pl[i], 1'b0);
        if (i == 0 && toggle_mid) ctrl = ~ctrl;
      end
      maybe_gap(gaps);
      beat(seq, 1'b1);
    end else begin
      for (int i = 0; i < n; i++) begin
        maybe_gap(gaps);
        l = (i == n - 1);
        beat(pl[i], l);
        if (i == 0 && toggle_mid) ctrl = ~ctrl;
      end
    end
    check_eq("seq_err_pulse", seq_err, last_exp_err);
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    model_clr();
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || m_valid) && k < 400) begin
      @(posedge clk);
      #1;
      k++;
    end
    check_eq("drain", exp_q.size(), 0);
  endtask

  // Output monitor: handshake seen at the falling edge completes at the next rising edge
  logic [32:0] mon_e;
  always @(negedge clk) begin
    if (!sys_reset && m_valid && m_ready) begin
      check_eq("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check_eq("out_beat", {m_last, m_data}, mon_e);
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    rnd_rdy = ($urandom_range(0, 4) != 0);
  end

  initial begin
    sys_reset = 1'b1;
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    ctrl = 1'b0; clr = 1'b0; dir_rdy = 1'b1; rnd_mode = 1'b0; rnd_rdy = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    sys_reset = 1'b0;
    idle(1);

    // Reset state
    check_eq("rst_tvalid", m_valid, 0);
    check_eq("rst_tdata", {m_last, m_data}, 0);
    check_eq("rst_seq_last", seq_last, 0);
    check_eq("rst_flags", {seq_err, ovf_err}, 0);
    check_eq("rst_cnts", {frame_cnt, seq_err_cnt, drop_cnt, runt_cnt}, 0);

    // Basic strip: A,B,C seq 5 then D seq 6
    ctrl = 1'b1;
    idle(1);
    pl = '{32'hA000_000A, 32'hB000_000B, 32'hC000_000C};
    send_frame(32'd5, 0, 0);
    pl = '{32'hD000_000D};
    send_frame(32'd6, 0, 0);
    wait_drain();
    check_eq("t1_seq_last", seq_last, m_seq_last);
    check_eq("t1_frame_cnt", frame_cnt, exp_cnt(m_frames));
    check_eq("t1_seq_err_cnt", seq_err_cnt, exp_cnt(m_serr));

    // Discontinuity and wrap, after a pass frame forces resynchronisation
    clr_pulse();
    ctrl = 1'b0;
    pl = '{32'h0000_0001};
    send_frame(32'd0, 0, 0);
    ctrl = 1'b1;
    pl = '{32'h1111_0001, 32'h1111_0002};
    send_frame(32'd10, 0, 0);
    send_frame(32'd12, 0, 0);
    send_frame(32'hFFFF_FFFF, 0, 0);
    send_frame(32'h0000_0000, 0, 0);
    wait_drain();
    check_eq("t2_seq_err_cnt", seq_err_cnt, exp_cnt(m_serr));
    check_eq("t2_seq_last", seq_last, m_seq_last);

    // Runt frame
    pl.delete();
    send_frame(32'd7, 0, 0);
    idle(3);
    check_eq("t3_no_output", m_valid, 0);
    check_eq("t3_runt_cnt", runt_cnt, exp_cnt(m_runts));
    check_eq("t3_seq_last", seq_last, m_seq_last);

    // Pass mode with a mid-frame toggle that only affects the next frame
    ctrl = 1'b0;
    pl = '{32'h5555_AAAA, 32'h7777_3333};
    send_frame(32'd0, 1, 0);
    wait_drain();
    check_eq("t4_seq_last_kept", seq_last, m_seq_last);
    pl = '{32'h2222_2222};
    send_frame(32'd200, 0, 0);
    wait_drain();
    check_eq("t4_seq_last", seq_last, m_seq_last);

    // Overflow: 20 non-last beats with the sink stalled
    dir_rdy = 1'b0;
    m_frames++;
    for (int i = 1; i <= 20; i++) begin
      if (i <= 17 && i >= 2) exp_q.push_back({1'b0, 32'(i - 1)});
      beat(32'(i), 1'b0);
    end
    m_drops += 3;
    m_ovf = 1;
    check_eq("t5_ovf_err", ovf_err, m_ovf);
    check_eq("t5_drop_cnt", drop_cnt, exp_cnt(m_drops));
    check_eq("t5_head", {m_valid, m_data}, {1'b1, 32'd1});
    dir_rdy = 1'b1;
    wait_drain();
    exp_q.push_back({1'b1, 32'd20});
    model_seq(m_seq_last + 32'd1);
    beat(m_seq_last, 1'b1);
    check_eq("t5_seq_err", seq_err, last_exp_err);
    wait_drain();
    check_eq("t5_ovf_sticky", ovf_err, 1);

    // Clear, including a clear coincident with a counted runt frame
    clr_pulse();
    check_eq("t6_ovf_clr", ovf_err, m_ovf);
    clr = 1'b1;
    pl.delete();
    send_frame(m_seq_last + 32'd1, 0, 0);
    clr = 1'b0;
    model_clr();
    check_eq("t6_clr_wins", {frame_cnt, runt_cnt}, {exp_cnt(m_frames), exp_cnt(m_runts)});

    // Reset in the middle of a frame
    dir_rdy = 1'b0;
    beat(32'h0000_0011, 1'b0);
    beat(32'h0000_0022, 1'b0);
    check_eq("t7_latency", m_valid, 1);
    #3;
    sys_reset = 1'b1;
    #1;
    check_eq("t7_async_drop", m_valid, 0);
    model_reset();
    @(posedge clk);
    #1;
    sys_reset = 1'b0;
    idle(1);
    dir_rdy = 1'b1;
    pl = '{32'h0000_0033, 32'h0000_0044};
    send_frame(32'd100, 0, 0);
    wait_drain();
    check_eq("t7_seq_last", seq_last, m_seq_last);
    check_eq("t7_frame_cnt", frame_cnt, exp_cnt(m_frames));

    // Randomized frames
    rnd_mode = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int          n;
      logic [31:0] sq;
      ctrl = ($urandom_range(0, 3) != 0);
      n = ctrl ? $urandom_range(0, 4) : $urandom_range(1, 4);
      pl.delete();
      for (int i = 0; i < n; i++) pl.push_back($urandom);
      sq = ($urandom_range(0, 3) == 0) ? $urandom : m_seq_last + 32'd1;
      send_frame(sq, 0, 1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    wait_drain();
    rnd_mode = 1'b0;
    check_eq("rnd_seq_last", seq_last, m_seq_last);
    check_eq("rnd_frame_cnt", frame_cnt, exp_cnt(m_frames));
    check_eq("rnd_seq_err_cnt", seq_err_cnt, exp_cnt(m_serr));
    check_eq("rnd_runt_cnt", runt_cnt, exp_cnt(m_runts));
    check_eq("rnd_ovf", {ovf_err, drop_cnt}, {1'b0, 16'(exp_cnt(m_drops))});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
